// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - DLX control encodings, FSM state type and strobe bundle
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [10:0] FN_ADD = 11'h020;
  localparam logic [10:0] FN_SUB = 11'h022;
  localparam logic [10:0] FN_AND = 11'h024;
  localparam logic [10:0] FN_OR  = 11'h025;
  localparam logic [10:0] FN_XOR = 11'h026;
  localparam logic [10:0] FN_SLL = 11'h004;
  localparam logic [10:0] FN_SRL = 11'h006;
  localparam logic [10:0] FN_SLT = 11'h02A;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_PASS_S1 = 4'd8;
  localparam logic [3:0] ALU_INC4    = 4'd9;

  localparam logic [1:0] DST_RD  = 2'd0;
  localparam logic [1:0] DST_RS2 = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  typedef enum logic [4:0] {
    ST_RESET, ST_FETCH, ST_IFETCH, ST_DECODE, ST_ALU_R, ST_ALU_I, ST_WB,
    ST_MEM_ADDR, ST_LOAD, ST_STORE, ST_BRANCH, ST_BR_TAKE, ST_JUMP,
    ST_LINK, ST_JUMP_J, ST_HALT, ST_TRAP
  } ctrl_state_t;

  typedef struct packed {
    logic       ir_oe_s1;
    logic       imm26_sel;
    logic       ir_oe_s2;
    logic       pc_load;
    logic       pc_oe_s1;
    logic       pc_oe_s2;
    logic       a_load;
    logic       b_load;
    logic       a_oe_s1;
    logic       b_oe_s2;
    logic       c_load;
    logic       mar_load;
    logic       mem_req;
    logic       mem_we;
    logic       regfile_we;
    logic [3:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/dlx_ctrl_decode.sv
// rtl/dlx_ctrl_decode.sv - instruction dispatch: opcode/func to next state, alu_op, legal
module dlx_ctrl_decode
  import dlx_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [10:0] i_opcodeALU,
  output ctrl_state_t o_next_state,
  output logic [3:0]  o_alu_op,
  output logic        o_legal
);

  always_comb begin
    o_next_state = ST_TRAP;
    o_alu_op     = ALU_ADD;
    o_legal      = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        o_next_state = ST_ALU_R;
        case (i_opcodeALU)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_XOR:  o_alu_op = ALU_XOR;
          FN_SLL:  o_alu_op = ALU_SLL;
          FN_SRL:  o_alu_op = ALU_SRL;
          FN_SLT:  o_alu_op = ALU_SLT;
          default: o_legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        o_next_state = ST_ALU_I;
        o_alu_op     = ALU_ADD;
      end
      OP_ANDI: begin
        o_next_state = ST_ALU_I;
        o_alu_op     = ALU_AND;
      end
      OP_ORI: begin
        o_next_state = ST_ALU_I;
        o_alu_op     = ALU_OR;
      end
      OP_LW, OP_SW:     o_next_state = ST_MEM_ADDR;
      OP_BEQZ, OP_BNEZ: o_next_state = ST_BRANCH;
      OP_J, OP_JAL:     o_next_state = ST_JUMP;
      OP_HALT:          o_next_state = ST_HALT;
      default:          o_legal      = 1'b0;
    endcase
    if (!o_legal) o_next_state = ST_TRAP;
  end

endmodule

// File: rtl/dlx_control_fsm.sv
// rtl/dlx_control_fsm.sv - multi-cycle DLX control sequencer with memory handshake waits
module dlx_control_fsm
  import dlx_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [5:0]  i_opcode,
  input  logic [10:0] i_opcodeALU,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_IRload,
  output logic        o_IRoeS1,
  output logic        o_imm26_sel,
  output logic        o_IRoeS2,
  output logic        o_PCload,
  output logic        o_PCoeS1,
  output logic        o_PCoeS2,
  output logic        o_Aload,
  output logic        o_Bload,
  output logic        o_AoeS1,
  output logic        o_BoeS2,
  output logic        o_Cload,
  output logic        o_MARload,
  output logic        o_MDRload,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_regfile_we,
  output logic [1:0]  o_reg_dst_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_halted,
  output logic        o_illegal
);

  ctrl_state_t r_state;
  ctrl_out_t   r_out;
  logic [1:0]  r_reg_dst;
  logic        r_is_sw;
  logic        r_is_bnez;
  logic        r_is_jal;

  ctrl_state_t w_next;
  ctrl_state_t w_dec_state;
  ctrl_out_t   w_out;
  logic [3:0]  w_dec_alu;
  logic        w_dec_legal;
  logic        w_is_jal;
  logic        w_taken;

  dlx_ctrl_decode u_decode (
    .i_opcode     (i_opcode),
    .i_opcodeALU  (i_opcodeALU),
    .o_next_state (w_dec_state),
    .o_alu_op     (w_dec_alu),
    .o_legal      (w_dec_legal)
  );

  assign w_is_jal = (i_opcode == OP_JAL);
  assign w_taken  = r_is_bnez ? !i_zero : i_zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:    w_next = ST_FETCH;
      ST_FETCH:    w_next = ST_IFETCH;
      ST_IFETCH:   if (i_mem_ready) w_next = ST_DECODE;
      ST_DECODE:   w_next = w_dec_legal ? w_dec_state : ST_TRAP;
      ST_ALU_R:    w_next = ST_WB;
      ST_ALU_I:    w_next = ST_WB;
      ST_WB:       w_next = ST_FETCH;
      ST_MEM_ADDR: w_next = r_is_sw ? ST_STORE : ST_LOAD;
      ST_LOAD:     if (i_mem_ready) w_next = ST_WB;
      ST_STORE:    if (i_mem_ready) w_next = ST_FETCH;
      ST_BRANCH:   w_next = w_taken ? ST_BR_TAKE : ST_FETCH;
      ST_BR_TAKE:  w_next = ST_FETCH;
      ST_JUMP:     w_next = r_is_jal ? ST_LINK : ST_FETCH;
      ST_LINK:     w_next = ST_JUMP_J;
      ST_JUMP_J:   w_next = ST_FETCH;
      ST_HALT:     w_next = ST_HALT;
      ST_TRAP:     w_next = ST_TRAP;
      default:     w_next = ST_RESET;
    endcase
  end

  // Strobes are decoded from the state being entered so they register alongside it.
  always_comb begin
    w_out = '0;
    case (w_next)
      ST_FETCH: begin
        w_out.pc_oe_s1 = 1'b1;
        w_out.alu_op   = ALU_PASS_S1;
        w_out.mar_load = 1'b1;
      end
      ST_IFETCH: w_out.mem_req = 1'b1;
      ST_DECODE: begin
        w_out.a_load   = 1'b1;
        w_out.b_load   = 1'b1;
        w_out.pc_oe_s1 = 1'b1;
        w_out.alu_op   = ALU_INC4;
        w_out.pc_load  = 1'b1;
      end
      ST_ALU_R: begin
        w_out.a_oe_s1 = 1'b1;
        w_out.b_oe_s2 = 1'b1;
        w_out.alu_op  = w_dec_alu;
        w_out.c_load  = 1'b1;
      end
      ST_ALU_I: begin
        w_out.a_oe_s1  = 1'b1;
        w_out.ir_oe_s2 = 1'b1;
        w_out.alu_op   = w_dec_alu;
        w_out.c_load   = 1'b1;
      end
      ST_WB, ST_LINK: w_out.regfile_we = 1'b1;
      ST_MEM_ADDR: begin
        w_out.a_oe_s1  = 1'b1;
        w_out.ir_oe_s2 = 1'b1;
        w_out.alu_op   = ALU_ADD;
        w_out.mar_load = 1'b1;
      end
      ST_LOAD: w_out.mem_req = 1'b1;
      ST_STORE: begin
        w_out.mem_req = 1'b1;
        w_out.mem_we  = 1'b1;
        w_out.b_oe_s2 = 1'b1;
      end
      ST_BRANCH: begin
        w_out.a_oe_s1 = 1'b1;
        w_out.alu_op  = ALU_PASS_S1;
      end
      ST_BR_TAKE: begin
        w_out.pc_oe_s2 = 1'b1;
        w_out.ir_oe_s1 = 1'b1;
        w_out.alu_op   = ALU_ADD;
        w_out.pc_load  = 1'b1;
      end
      ST_JUMP, ST_JUMP_J: begin
        if (w_next == ST_JUMP && w_is_jal) begin
          w_out.pc_oe_s1 = 1'b1;
          w_out.alu_op   = ALU_PASS_S1;
          w_out.c_load   = 1'b1;
        end else begin
          w_out.pc_oe_s2  = 1'b1;
          w_out.ir_oe_s1  = 1'b1;
          w_out.imm26_sel = 1'b1;
          w_out.alu_op    = ALU_ADD;
          w_out.pc_load   = 1'b1;
        end
      end
      ST_HALT: w_out.halted  = 1'b1;
      ST_TRAP: w_out.illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_RESET;
      r_out     <= '0;
      r_reg_dst <= DST_RD;
      r_is_sw   <= 1'b0;
      r_is_bnez <= 1'b0;
      r_is_jal  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= w_out;
      if (r_state == ST_DECODE) begin
        r_is_sw   <= (i_opcode == OP_SW);
        r_is_bnez <= (i_opcode == OP_BNEZ);
        r_is_jal  <= w_is_jal;
      end
      if (w_next == ST_WB)
        r_reg_dst <= (r_state == ST_ALU_R) ? DST_RD : DST_RS2;
      else if (w_next == ST_LINK)
        r_reg_dst <= DST_R31;
    end
  end

  // Capture strobes complete in the same cycle memory answers.
  assign o_IRload      = (r_state == ST_IFETCH) && i_mem_ready;
  assign o_MDRload     = (r_state == ST_LOAD) && i_mem_ready;
  assign o_IRoeS1      = r_out.ir_oe_s1;
  assign o_imm26_sel   = r_out.imm26_sel;
  assign o_IRoeS2      = r_out.ir_oe_s2;
  assign o_PCload      = r_out.pc_load;
  assign o_PCoeS1      = r_out.pc_oe_s1;
  assign o_PCoeS2      = r_out.pc_oe_s2;
  assign o_Aload       = r_out.a_load;
  assign o_Bload       = r_out.b_load;
  assign o_AoeS1       = r_out.a_oe_s1;
  assign o_BoeS2       = r_out.b_oe_s2;
  assign o_Cload       = r_out.c_load;
  assign o_MARload     = r_out.mar_load;
  assign o_mem_req     = r_out.mem_req;
  assign o_mem_we      = r_out.mem_we;
  assign o_regfile_we  = r_out.regfile_we;
  assign o_reg_dst_sel = r_reg_dst;
  assign o_alu_op      = r_out.alu_op;
  assign o_halted      = r_out.halted;
  assign o_illegal     = r_out.illegal;

endmodule
